// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        MATCH = 1'b1
    } state_t;

    // A zero length means "single bit"; anything past the shift depth is capped at it.
    function automatic int unsigned clamp_len(input int unsigned len_raw,
                                              input int unsigned max_len);
        if (len_raw == 0)
            return 1;
        else if (len_raw > max_len)
            return max_len;
        else
            return len_raw;
    endfunction

endpackage

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loadable pattern/length, selectable overlap,
// a one-cycle Moore match pulse and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 4'hB,
    localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             x,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             armed
);

    // The oldest history bit would only ever be shifted out, so only PAT_W-1 are kept.
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             armed_q, armed_d;

    logic             accept;
    logic             hit;
    logic [PAT_W-1:0] shifted;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W:0]   fill_inc;

    always_comb begin
        accept   = in_valid & ~pat_load;
        shifted  = {hist_q, x};
        fill_inc = {1'b0, fill_q} + (LEN_W + 1)'(1);
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        hit = accept && (fill_inc >= {1'b0, len_q}) &&
              ((shifted & len_mask) == (pat_q & len_mask));
    end

    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = hit ? MATCH : HUNT;

        if (pat_load) begin
            pat_d  = pat_in;
            len_d  = LEN_W'(clamp_len(32'(len_in), PAT_W));
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = shifted[PAT_W-2:0];
            // Non-overlapping mode restarts the window so the next match needs len fresh bits.
            if (hit && !overlap_en)
                fill_d = '0;
            else if (fill_q < LEN_W'(PAT_W))
                fill_d = fill_inc[LEN_W-1:0];
        end

        armed_d = (fill_d >= len_d);
    end

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (cnt_clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else begin
            if (hit && (cnt_q != '1))
                cnt_d = cnt_q + CNT_W'(1);
            sat_d = sat_q | (cnt_d == '1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= RST_PAT;
            len_q   <= LEN_W'(PAT_W);
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= HUNT;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            armed_q <= armed_d;
        end
    end

    assign match     = (state_q == MATCH);
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;
    assign armed     = armed_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic, all checked
// against a queue-based model of the accepted bit stream.
module tb_seq_detector_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             x;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic [LEN_W-1:0] len_in;
    logic             overlap_en;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;
    logic             armed;

    int total = 0;
    int bad   = 0;

    seq_detector_param #(
        .PAT_W  (PAT_W),
        .CNT_W  (CNT_W),
        .RST_PAT(4'hB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .len_in    (len_in),
        .overlap_en(overlap_en),
        .cnt_clr   (cnt_clr),
        .match     (match),
        .match_cnt (match_cnt),
        .cnt_sat   (cnt_sat),
        .armed     (armed)
    );

    always #5 clk = ~clk;

    // Reference state: pattern, length, the recent accepted bits and how many
    // fresh bits have arrived since the window last restarted.
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_bits[$];
    int               m_since;
    int               m_cnt;
    bit               m_sat;
    bit               m_match;
    bit               m_armed;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat   = 4'hB;
        m_len   = PAT_W;
        m_bits.delete();
        m_since = 0;
        m_cnt   = 0;
        m_sat   = 1'b0;
        m_match = 1'b0;
        m_armed = 1'b0;
    endtask

    task automatic model_update(input bit iv, input bit xb, input bit pl,
                                input logic [PAT_W-1:0] pin, input int lin,
                                input bit ov, input bit clr);
        bit hit;
        hit = 1'b0;
        if (pl) begin
            m_pat = pin;
            m_len = (lin == 0) ? 1 : ((lin > PAT_W) ? PAT_W : lin);
            m_bits.delete();
            m_since = 0;
        end else if (iv) begin
            m_bits.push_back(xb);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            if (m_since + 1 >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++) begin
                    if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                end
            end
            if (hit && !ov) m_since = 0;
            else if (m_since < PAT_W) m_since = m_since + 1;
        end
        m_match = hit;
        if (clr) begin
            m_cnt = 0;
            m_sat = 1'b0;
        end else begin
            if (hit && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (m_cnt == CMAX) m_sat = 1'b1;
        end
        m_armed = (m_since >= m_len);
    endtask

    task automatic step(input bit iv, input bit xb, input bit pl,
                        input logic [PAT_W-1:0] pin, input int lin,
                        input bit ov, input bit clr);
        in_valid   = iv;
        x          = xb;
        pat_load   = pl;
        pat_in     = pin;
        len_in     = LEN_W'(lin);
        overlap_en = ov;
        cnt_clr    = clr;
        model_update(iv, xb, pl, pin, lin, ov, clr);
        @(posedge clk);
        #1;
        chk("match", 32'(match), 32'(m_match));
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
        chk("cnt_sat", 32'(cnt_sat), 32'(m_sat));
        chk("armed", 32'(armed), 32'(m_armed));
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) step(1, bits[i], 0, '0, 0, ov, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 0; x = 0; pat_load = 0; pat_in = '0;
        len_in = '0; overlap_en = 0; cnt_clr = 0;
        model_reset();
        #1;
        chk("rst_match", 32'(match), 0);
        chk("rst_cnt", 32'(match_cnt), 0);
        chk("rst_sat", 32'(cnt_sat), 0);
        chk("rst_armed", 32'(armed), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Overlapping detection of 1011 in 1011011: pulses after bits 4 and 7.
        send_bits(32'b101, 3, 1);
        step(1, 1, 0, '0, 0, 1, 0);
        chk("ov_b4_match", 32'(match), 1);
        send_bits(32'b01, 2, 1);
        step(1, 1, 0, '0, 0, 1, 0);
        chk("ov_b7_match", 32'(match), 1);
        chk("ov_cnt", 32'(match_cnt), 2);

        // Non-overlapping: only the first occurrence counts.
        step(0, 0, 1, 4'hB, 4, 0, 1);
        send_bits(32'b1011011, 7, 0);
        chk("nov_cnt", 32'(match_cnt), 1);
        chk("nov_armed", 32'(armed), 0);

        // Length 2, pattern 01, with idle cycles between bits.
        step(0, 0, 1, 4'b0001, 2, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, bit'(i % 2), 0, '0, 0, 0, 0);
            step(0, 0, 0, '0, 0, 0, 0);
            chk("gap_idle_match", 32'(match), 0);
        end
        chk("gap_cnt", 32'(match_cnt), 2);

        // A load mid-pattern drops the concurrent bit and the old prefix.
        step(0, 0, 1, 4'hB, 4, 1, 1);
        send_bits(32'b101, 3, 1);
        step(1, 1, 1, 4'hB, 4, 1, 0);
        chk("load_armed", 32'(armed), 0);
        step(1, 1, 0, '0, 0, 1, 0);
        chk("load_nomatch", 32'(match), 0);
        send_bits(32'b011, 3, 1);
        chk("load_fresh_match", 32'(match), 1);

        // Length clamping: 0 acts as 1, 7 acts as PAT_W.
        step(0, 0, 1, 4'b0001, 0, 1, 0);
        step(1, 1, 0, '0, 0, 1, 0);
        chk("len0_match", 32'(match), 1);
        step(0, 0, 1, 4'b0110, 7, 1, 0);
        send_bits(32'b0110, 4, 1);
        chk("len7_match", 32'(match), 1);

        // Saturation, then a clear in the same cycle as a hit.
        step(0, 0, 1, 4'b0001, 1, 1, 1);
        for (int i = 0; i < CMAX + 1; i++) step(1, 1, 0, '0, 0, 1, 0);
        chk("sat_cnt", 32'(match_cnt), CMAX);
        chk("sat_flag", 32'(cnt_sat), 1);
        step(1, 1, 0, '0, 0, 1, 1);
        chk("clr_cnt", 32'(match_cnt), 0);
        chk("clr_match", 32'(match), 1);
        chk("clr_sat", 32'(cnt_sat), 0);

        // Asynchronous reset during bit 3 of 1011.
        step(0, 0, 1, 4'hB, 4, 1, 0);
        send_bits(32'b1011, 4, 1);
        send_bits(32'b10, 2, 1);
        in_valid = 1; x = 1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_match", 32'(match), 0);
        chk("arst_cnt", 32'(match_cnt), 0);
        chk("arst_sat", 32'(cnt_sat), 0);
        chk("arst_armed", 32'(armed), 0);
        model_reset();
        @(posedge clk);
        #1;
        in_valid = 0;
        rst_n = 1'b1;
        step(1, 1, 0, '0, 0, 1, 0);
        chk("arst_stale_match", 32'(match), 0);
        send_bits(32'b011, 3, 1);
        chk("arst_fresh_match", 32'(match), 1);

        // Random traffic.
        begin
            bit ov;
            ov = 1'b1;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 19) == 0) ov = ~ov;
                step(($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                     ($urandom_range(0, 39) == 0), PAT_W'($urandom_range(0, 15)),
                     int'($urandom_range(0, 7)), ov, ($urandom_range(0, 99) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
